save_load_slots: RTL and testbench

//  Responder for the VGA front-end's save/load requests. Holds NUM_SLOTS hit-map snapshots.

---
 rtl/save_load_pkg.sv | 24 ++
 rtl/slot_request_debounce.sv | 43 ++++
 rtl/save_load_slots.sv | 121 ++++++++++++
 tb/tb_save_load_slots.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/save_load_pkg.sv
// Shared constants for the save/load slot responder: slot codes, FSM state
// encoding and the slot-code range check used by both request channels.
package save_load_pkg;

  localparam logic [31:0] NONE = 32'd0;
  localparam logic [31:0] LOC1 = 32'd1;
  localparam logic [31:0] LOC2 = 32'd2;
  localparam logic [31:0] LOC3 = 32'd3;

  // state | meaning
  // IDLE  | no operation in flight
  // SAVE  | one-cycle slot write, committed on the exit edge
  // LOAD  | one-cycle slot read, sensor_output updated on the exit edge
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SAVE = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  // A code addresses a slot only when it lies in 1..num_slots.
  function automatic logic slot_code_valid(input logic [31:0] code,
                                           input int unsigned num_slots);
    return (code != NONE) && (code <= num_slots);
  endfunction

endpackage

// File: rtl/slot_request_debounce.sv
// Qualifies one request channel: a code must be seen on HOLD_CYCLES
// consecutive clocks before it fires, and fires only once per code change.
// code_out carries the qualified code alongside the fire pulse.
module slot_request_debounce
  import save_load_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned NUM_SLOTS   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] code_in,
  output logic        fire,
  output logic [31:0] code_out
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);

  logic [31:0]      prev_code;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  assign fire     = armed && (cnt == HOLD_CNT) && slot_code_valid(prev_code, NUM_SLOTS);
  assign code_out = prev_code;

  // Track run length of the current code; disarm after firing until the code changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_code <= '0;
      cnt       <= '0;
      armed     <= 1'b1;
    end else if (code_in != prev_code) begin
      prev_code <= code_in;
      cnt       <= CNT_W'(1);
      armed     <= 1'b1;
    end else begin
      if (cnt != HOLD_CNT) cnt <= cnt + CNT_W'(1);
      if (fire) armed <= 1'b0;
    end
  end

endmodule

// File: rtl/save_load_slots.sv
// Save/load slot responder for the VGA front-end. Holds NUM_SLOTS snapshots,
// commits saves and returns loads, one operation per cycle, save first.
// Build option: define SLOT_ACCUMULATE_EN to OR new data into a slot on save
// instead of overwriting it.
module save_load_slots
  import save_load_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLOTS   = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          save_signal,
  input  logic [31:0]          load_signal,
  input  logic [DATA_W-1:0]    sensor_input_to_save,
  output logic [DATA_W-1:0]    sensor_output,
  output logic                 save_done,
  output logic                 load_valid,
  output logic                 load_empty,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 busy
);

  logic        save_fire, load_fire;
  logic [31:0] save_code, load_code;
  logic        load_pend;
  logic [31:0] load_pend_code;
  logic        load_req;
  logic [31:0] load_req_code;
  logic [1:0]  state;
  logic [31:0] cur_code;
  logic [DATA_W-1:0] slot [NUM_SLOTS];

  slot_request_debounce #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .NUM_SLOTS   (NUM_SLOTS)
  ) u_save_dbnc (
    .clock    (clock),
    .reset    (reset),
    .code_in  (save_signal),
    .fire     (save_fire),
    .code_out (save_code)
  );

  slot_request_debounce #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .NUM_SLOTS   (NUM_SLOTS)
  ) u_load_dbnc (
    .clock    (clock),
    .reset    (reset),
    .code_in  (load_signal),
    .fire     (load_fire),
    .code_out (load_code)
  );

  // A pending load is older than a fresh load fire, so it is served first.
  assign load_req      = load_pend | load_fire;
  assign load_req_code = load_pend ? load_pend_code : load_code;
  assign busy          = (state != IDLE) | load_pend;

  // Each operation state lasts one cycle; the next operation is picked every
  // cycle so a load deferred behind a save follows it immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cur_code       <= '0;
      load_pend      <= 1'b0;
      load_pend_code <= '0;
    end else begin
      if (save_fire) begin
        state    <= SAVE;
        cur_code <= save_code;
      end else if (load_req) begin
        state    <= LOAD;
        cur_code <= load_req_code;
      end else begin
        state    <= IDLE;
      end
      if (load_fire && (save_fire || load_pend)) begin
        load_pend      <= 1'b1;
        load_pend_code <= load_code;
      end else if (!save_fire) begin
        load_pend      <= 1'b0;
      end
    end
  end

  // Commit the in-flight operation on its exit edge and raise its pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) slot[i] <= '0;
      slot_valid    <= '0;
      sensor_output <= '0;
      save_done     <= 1'b0;
      load_valid    <= 1'b0;
      load_empty    <= 1'b0;
    end else begin
      save_done  <= (state == SAVE);
      load_valid <= (state == LOAD);
      load_empty <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (cur_code == 32'(i + 1)) begin
          if (state == SAVE) begin
`ifdef SLOT_ACCUMULATE_EN
            slot[i] <= slot[i] | sensor_input_to_save;
`else
            slot[i] <= sensor_input_to_save;
`endif
            slot_valid[i] <= 1'b1;
          end
          if (state == LOAD) begin
            sensor_output <= slot_valid[i] ? slot[i] : '0;
            load_empty    <= ~slot_valid[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_save_load_slots.sv
// Bench for save_load_slots: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_save_load_slots;

  localparam int DATA_W    = 32;
  localparam int NUM_SLOTS = 3;
  localparam int HOLD      = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       save_signal = '0;
  logic [31:0]       load_signal = '0;
  logic [DATA_W-1:0] sensor_input_to_save = '0;
  logic [DATA_W-1:0] sensor_output;
  logic              save_done, load_valid, load_empty, busy;
  logic [NUM_SLOTS-1:0] slot_valid;

  always #5 clock = ~clock;

  save_load_slots #(
    .DATA_W      (DATA_W),
    .NUM_SLOTS   (NUM_SLOTS),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .save_signal          (save_signal),
    .load_signal          (load_signal),
    .sensor_input_to_save (sensor_input_to_save),
    .sensor_output        (sensor_output),
    .save_done            (save_done),
    .load_valid           (load_valid),
    .load_empty           (load_empty),
    .slot_valid           (slot_valid),
    .busy                 (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        is_load;
    logic [31:0] code;
  } op_t;

  op_t         q[$];
  op_t         m_op;
  logic        m_op_on = 1'b0;
  logic [31:0] m_slot [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] m_valid = '0;
  logic [31:0] m_out = '0;
  logic        m_sd = 1'b0, m_lv = 1'b0, m_le = 1'b0, m_busy = 1'b0;
  logic [31:0] last_s = '0, last_l = '0;
  int          run_s = 0, run_l = 0;

  function automatic bit code_ok(input logic [31:0] c);
    return (c >= 1) && (c <= NUM_SLOTS);
  endfunction

  // A request is qualified when its code has been sampled HOLD times in a
  // row; it joins a queue (save before load) and is executed one clock after
  // leaving the queue, one operation per clock.
  initial begin
    for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = '0;
    forever begin
      @(posedge clock);
      if (reset) begin
        q.delete();
        m_op_on = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = '0;
        m_valid = '0; m_out = '0;
        m_sd = 1'b0; m_lv = 1'b0; m_le = 1'b0; m_busy = 1'b0;
        last_s = '0; last_l = '0; run_s = 0; run_l = 0;
      end else begin
        int idx;
        m_sd = 1'b0; m_lv = 1'b0; m_le = 1'b0;
        if (m_op_on) begin
          idx = int'(m_op.code) - 1;
          if (!m_op.is_load) begin
`ifdef SLOT_ACCUMULATE_EN
            m_slot[idx] = m_slot[idx] | sensor_input_to_save;
`else
            m_slot[idx] = sensor_input_to_save;
`endif
            m_valid[idx] = 1'b1;
            m_sd = 1'b1;
          end else begin
            m_lv  = 1'b1;
            m_le  = !m_valid[idx];
            m_out = m_valid[idx] ? m_slot[idx] : 32'd0;
          end
        end
        if (run_s == HOLD && code_ok(last_s)) q.push_back('{is_load: 1'b0, code: last_s});
        if (run_l == HOLD && code_ok(last_l)) q.push_back('{is_load: 1'b1, code: last_l});
        m_op_on = (q.size() > 0);
        if (m_op_on) m_op = q.pop_front();
        if (save_signal == last_s) run_s++;
        else begin last_s = save_signal; run_s = 1; end
        if (load_signal == last_l) run_l++;
        else begin last_l = load_signal; run_l = 1; end
        m_busy = m_op_on || (q.size() != 0);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clock);
      check("save_done",     {63'd0, save_done},  {63'd0, m_sd});
      check("load_valid",    {63'd0, load_valid}, {63'd0, m_lv});
      check("load_empty",    {63'd0, load_empty}, {63'd0, m_le});
      check("sensor_output", {32'd0, sensor_output}, {32'd0, m_out});
      check("slot_valid",    {61'd0, slot_valid}, {61'd0, m_valid});
      check("busy",          {63'd0, busy},       {63'd0, m_busy});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_req(input logic [31:0] s, input logic [31:0] l, input logic [31:0] d,
                         input int hold, input int watch,
                         output int sd_n, output int sd_at, output int lv_n, output int lv_at,
                         output logic [31:0] out_lv, output logic le_lv);
    sd_n = 0; sd_at = -1; lv_n = 0; lv_at = -1; out_lv = '0; le_lv = 1'b0;
    @(negedge clock);
    save_signal = s; load_signal = l; sensor_input_to_save = d;
    for (int k = 1; k <= watch; k++) begin
      @(posedge clock); #1;
      if (save_done) begin sd_n++; sd_at = k; end
      if (load_valid) begin lv_n++; lv_at = k; out_lv = sensor_output; le_lv = load_empty; end
      if (k == hold) begin save_signal = '0; load_signal = '0; end
    end
  endtask

  function automatic logic [31:0] pick_code(input logic [31:0] cur);
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return 32'($urandom_range(0, 3));
      5:             return 32'd4;
      6:             return $urandom;
      default:       return cur;
    endcase
  endfunction

  int sd_n, sd_at, lv_n, lv_at;
  logic [31:0] out_lv;
  logic le_lv;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset slot_valid", {61'd0, slot_valid}, 64'd0);
    check("reset sensor_output", {32'd0, sensor_output}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);

    // save slot 2
    run_req(32'd2, 32'd0, 32'h0000_00FF, 6, 9, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
    check("t1 save_done count", 64'(sd_n), 64'd1);
    check("t1 save_done clk", 64'(sd_at), 64'd6);
    check("t1 slot_valid", {61'd0, slot_valid}, 64'b010);

    // load slot 2
    run_req(32'd0, 32'd2, 32'h1234_5678, 6, 9, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
    check("t2 load_valid count", 64'(lv_n), 64'd1);
    check("t2 load_valid clk", 64'(lv_at), 64'd6);
    check("t2 data", {32'd0, out_lv}, 64'h0000_00FF);
    check("t2 empty", {63'd0, le_lv}, 64'd0);

    // load unsaved slot 3
    run_req(32'd0, 32'd3, 32'h1234_5678, 6, 9, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
    check("t3 load_valid clk", 64'(lv_at), 64'd6);
    check("t3 data", {32'd0, out_lv}, 64'd0);
    check("t3 empty", {63'd0, le_lv}, 64'd1);

    // save code chattering 0/1 every two clocks never qualifies
    sd_n = 0;
    for (int k = 0; k < 26; k++) begin
      @(negedge clock);
      save_signal = (k < 20 && ((k / 2) % 2) == 1) ? 32'd1 : 32'd0;
      @(posedge clock); #1;
      if (save_done) sd_n++;
    end
    check("t4 save_done count", 64'(sd_n), 64'd0);
    check("t4 slot_valid", {61'd0, slot_valid}, 64'b010);

    // simultaneous save and load of slot 1
    run_req(32'd1, 32'd1, 32'hA5A5_0001, 6, 10, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
    check("t5 save_done clk", 64'(sd_at), 64'd6);
    check("t5 load_valid clk", 64'(lv_at), 64'd7);
    check("t5 data", {32'd0, out_lv}, 64'hA5A5_0001);
    check("t5 empty", {63'd0, le_lv}, 64'd0);

    // reset while in SAVE aborts the write
    @(negedge clock);
    save_signal = 32'd3; sensor_input_to_save = 32'hDEAD_BEEF;
    sd_n = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      if (save_done) sd_n++;
    end
    check("rst busy in save", {63'd0, busy}, 64'd1);
    reset = 1'b1; save_signal = '0;
    @(posedge clock); #1;
    if (save_done) sd_n++;
    check("rst slot_valid", {61'd0, slot_valid}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (save_done) sd_n++;
    end
    check("rst save_done count", 64'(sd_n), 64'd0);
    check("rst slot_valid late", {61'd0, slot_valid}, 64'd0);
    run_req(32'd0, 32'd3, 32'h0, 6, 9, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
    check("rst slot3 empty", {63'd0, le_lv}, 64'd1);

    // two saves to slot 1 then load it
    run_req(32'd1, 32'd0, 32'h1, 6, 8, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
    run_req(32'd1, 32'd0, 32'h4, 6, 8, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
    run_req(32'd0, 32'd1, 32'h0, 6, 9, sd_n, sd_at, lv_n, lv_at, out_lv, le_lv);
`ifdef SLOT_ACCUMULATE_EN
    check("t6 merged data", {32'd0, out_lv}, 64'h5);
`else
    check("t6 overwrite data", {32'd0, out_lv}, 64'h4);
`endif

    // randomized phase
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        @(negedge clock);
        if (c == 0) begin
          reset       = ($urandom_range(0, 39) == 0);
          save_signal = pick_code(save_signal);
          load_signal = pick_code(load_signal);
        end else begin
          reset = 1'b0;
        end
        sensor_input_to_save = $urandom;
      end
    end
    @(negedge clock);
    reset = 1'b0; save_signal = '0; load_signal = '0;
    repeat (12) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
